// File: rtl/cabac_bin_sequencer_if.sv
// Handshake and control bundle between the CABAC bin sequencer and its command
// source, bitstream byte reader, decoder datapath and bin sink.
interface cabac_bin_sequencer_if #(
  parameter int BIN_WIDTH = 3,
  parameter int CNT_W     = 7
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           cmd_pstate;
  logic                 cmd_bypass;
  logic [CNT_W-1:0]     cmd_num_bins;

  logic [7:0]           dec_pstate;
  logic                 dec_bypass;
  logic [1:0]           dec_n_bin;
  logic                 dec_step;
  logic [2:0]           dec_num_bits;
  logic [BIN_WIDTH-1:0] dec_bin;

  logic                 byte_request;
  logic                 byte_ready;
  logic [2:0]           byte_shift;
  logic signed [3:0]    bits_needed;

  logic                 bin_valid;
  logic [BIN_WIDTH-1:0] bin_data;
  logic [1:0]           bin_count;
  logic                 bin_ready;
  logic                 busy;

  modport master (
    input  cmd_valid, cmd_pstate, cmd_bypass, cmd_num_bins,
    input  dec_num_bits, dec_bin, byte_ready, bin_ready,
    output cmd_ready, dec_pstate, dec_bypass, dec_n_bin, dec_step,
    output byte_request, byte_shift, bits_needed,
    output bin_valid, bin_data, bin_count, busy
  );

  modport slave (
    output cmd_valid, cmd_pstate, cmd_bypass, cmd_num_bins,
    output dec_num_bits, dec_bin, byte_ready, bin_ready,
    input  cmd_ready, dec_pstate, dec_bypass, dec_n_bin, dec_step,
    input  byte_request, byte_shift, bits_needed,
    input  bin_valid, bin_data, bin_count, busy
  );
endinterface

// File: rtl/cabac_bin_sequencer.sv
// CABAC bin decoder control sequencer: splits commands into decoder steps,
// tracks the bit budget and requests bitstream bytes on byte crossings.
module cabac_bin_sequencer #(
  parameter int BIN_WIDTH = 3,
  parameter int CNT_W     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  cabac_bin_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, WAIT_BYTE} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        pstate_reg, pstate_next;
  logic              bypass_reg, bypass_next;
  logic [CNT_W-1:0]  remaining_reg, remaining_next;
  logic signed [3:0] bits_needed_reg, bits_needed_next;
  logic              byte_request_reg, byte_request_next;
  logic [2:0]        byte_shift_reg, byte_shift_next;

  logic [2:0]        step_bins;
  logic [1:0]        n_bin;
  logic              step;
  logic [2:0]        cons;
  logic signed [3:0] idx;
  logic [CNT_W-1:0]  dec_amount;

  always_comb begin
    step_bins  = (remaining_reg < CNT_W'(BIN_WIDTH)) ? 3'(remaining_reg) : 3'(BIN_WIDTH);
    n_bin      = (state_reg == RUN && bypass_reg) ? 2'(step_bins - 3'd1) : 2'd0;
    step       = (state_reg == RUN) && bus.bin_ready;
    cons       = bypass_reg ? ({1'b0, n_bin} + 3'd1) : bus.dec_num_bits;
    // Budget is at most -1 and cons at most 7, so the sum always fits in 4 bits.
    idx        = bits_needed_reg + $signed({1'b0, cons});
    dec_amount = bypass_reg ? (CNT_W'(n_bin) + CNT_W'(1)) : CNT_W'(1);
  end

  always_comb begin
    state_next        = state_reg;
    pstate_next       = pstate_reg;
    bypass_next       = bypass_reg;
    remaining_next    = remaining_reg;
    bits_needed_next  = bits_needed_reg;
    byte_request_next = byte_request_reg;
    byte_shift_next   = byte_shift_reg;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          pstate_next    = bus.cmd_pstate;
          bypass_next    = bus.cmd_bypass;
          remaining_next = bus.cmd_num_bins;
          if (bus.cmd_num_bins != '0) state_next = RUN;
        end
      end
      RUN: begin
        if (step) begin
          remaining_next = remaining_reg - dec_amount;
          if (!idx[3]) begin
            // idx - 8 for idx in 0..6 is just the low bits with the sign bit set.
            bits_needed_next  = $signed({1'b1, idx[2:0]});
            byte_request_next = 1'b1;
            byte_shift_next   = idx[2:0];
            state_next        = WAIT_BYTE;
          end else begin
            bits_needed_next = idx;
            if (remaining_next == '0) state_next = IDLE;
          end
        end
      end
      WAIT_BYTE: begin
        if (bus.byte_ready) begin
          byte_request_next = 1'b0;
          state_next        = (remaining_reg != '0) ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      pstate_reg       <= 8'd0;
      bypass_reg       <= 1'b0;
      remaining_reg    <= '0;
      bits_needed_reg  <= -4'sd8;
      byte_request_reg <= 1'b0;
      byte_shift_reg   <= 3'd0;
    end else begin
      state_reg        <= state_next;
      pstate_reg       <= pstate_next;
      bypass_reg       <= bypass_next;
      remaining_reg    <= remaining_next;
      bits_needed_reg  <= bits_needed_next;
      byte_request_reg <= byte_request_next;
      byte_shift_reg   <= byte_shift_next;
    end
  end

  assign bus.cmd_ready    = (state_reg == IDLE);
  assign bus.busy         = (state_reg != IDLE);
  assign bus.dec_pstate   = pstate_reg;
  assign bus.dec_bypass   = bypass_reg;
  assign bus.dec_n_bin    = n_bin;
  assign bus.dec_step     = step;
  assign bus.byte_request = byte_request_reg;
  assign bus.byte_shift   = byte_shift_reg;
  assign bus.bits_needed  = bits_needed_reg;
  assign bus.bin_valid    = step;
  assign bus.bin_data     = bus.dec_bin;
  assign bus.bin_count    = n_bin;
endmodule

// File: doc/cabac_bin_sequencer.md
Name: cabac_bin_sequencer

Overview:
RTL control sequencer for the CABAC bin decoder. It accepts per-syntax-element commands (pState, bypass flag, bin count) and splits each command into decoder steps. For each step it drives the decoder's n_bin, pState and bypass controls, and tracks the bitstream bit budget (bits_needed). When a byte boundary is crossed it requests a new bitstream byte and tells the offset-update datapath which shift to apply. It sits between the command source, the bitstream byte reader and the Decoder datapath, and forwards decoded bins to a ready/valid sink.

Parameters:
BIN_WIDTH, 3, maximum bypass bins decoded per step (1..4); n_bin width is 2 bits.
CNT_W, 7, width of the bin count and remaining-bins counter.

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_pstate  input  8  context state for regular bins
cmd_bypass  input  1  1 = bypass bins, 0 = regular bins
cmd_num_bins  input  CNT_W  bins in this command
dec_pstate  output  8  latched cmd_pstate
dec_bypass  output  1  latched cmd_bypass
dec_n_bin  output  2  bins this step minus 1
dec_step  output  1  decoder advances this cycle
dec_num_bits  input  3  renorm bits consumed by the current regular bin (0..6)
dec_bin  input  BIN_WIDTH  bins from decoder, LSB first
byte_request  output  1  request next bitstream byte; held until byte_ready
byte_ready  input  1  byte delivered this cycle
byte_shift  output  3  bit position of the byte crossing; valid while byte_request
bits_needed  output  4  signed bit budget, range -8..-1
bin_valid  output  1  equals dec_step
bin_data  output  BIN_WIDTH  equals dec_bin
bin_count  output  2  equals dec_n_bin
bin_ready  input  1  sink accepts bins
busy  output  1  state != IDLE

Behaviour:
- Reset values:
  - state IDLE, bits_needed = -8, remaining = 0.
  - dec_pstate = 0, dec_bypass = 0, byte_shift = 0.
  - byte_request = 0, dec_step = 0, busy = 0, cmd_ready = 1.
- Reset is effective in any state, including mid-command or in WAIT_BYTE. Any pending byte request is dropped.
- States:
  - IDLE:
    - cmd_valid & cmd_ready latches pstate, bypass and remaining = cmd_num_bins.
    - If cmd_num_bins == 0, stay in IDLE (command consumed, no steps). Otherwise go to RUN next cycle.
  - RUN:
    - dec_n_bin (combinational):
      - bypass: min(remaining, BIN_WIDTH) - 1
      - regular: 0
    - dec_step = bin_ready. No step when bin_ready = 0; all state holds.
    - On a step:
      - cons = dec_n_bin + 1 (bypass) or dec_num_bits (regular).
      - idx = bits_needed + cons, 4-bit signed; worst case -1 + 7 = 6, no overflow.
      - If idx >= 0: bits_needed <= idx - 8, byte_request <= 1, byte_shift <= idx, go to WAIT_BYTE.
      - Otherwise: bits_needed <= idx.
      - remaining decrements by dec_n_bin + 1 (bypass) or 1 (regular).
      - If remaining reaches 0 and no byte request was raised, go to IDLE.
  - WAIT_BYTE:
    - dec_step = 0, byte_request = 1.
    - On byte_ready: byte_request <= 0, then go to RUN if remaining > 0, else IDLE.
- Latency:
  - The first step can occur the cycle after command acceptance.
  - One step per cycle while bin_ready is high and no byte is pending.
  - A byte crossing costs at least one stall cycle.
- bits_needed persists across commands; it is not reset per command.
- cmd_ready is never asserted while a byte request is outstanding.

Test Plan:
1. Reset asserted mid-RUN -> next edge: bits_needed = -8, state IDLE, cmd_ready = 1, byte_request = 0, busy = 0.
2. Bypass command, num_bins = 7, bin_ready = 1 -> three steps with dec_n_bin 2, 2, 0. bits_needed goes -8, -5, -2, -1. No byte_request; returns to IDLE after the 3rd step.
3. From bits_needed = -1, bypass command with num_bins = 2 -> idx = 1: byte_request = 1, byte_shift = 1, bits_needed = -7. byte_ready after 3 cycles -> dec_step stays 0 for those cycles, then IDLE.
4. Regular command, num_bins = 2, dec_num_bits 6 then 3, from -8 -> bits_needed -2, then request with byte_shift = 1, bits_needed = -7. Two bin_valid pulses, bin_count = 0.
5. bin_ready held low for 4 cycles during RUN -> no dec_step or bin_valid; remaining and bits_needed unchanged; resumes on release.
6. Command with num_bins = 0 -> accepted, no dec_step, cmd_ready stays 1; a following command with num_bins = 1 is accepted on the next cycle.
